// File: rtl/ram_sr_feeder.sv
// Feeds a raster pixel stream into the RAM-based window shift register and
// announces each complete KERNEL x KERNEL window with its top-left coordinates.
module ram_sr_feeder #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int KERNEL     = 3,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic          sr_enable,
  output logic [7:0]    sr_column_in,
  output logic          sr_shift_row_up,
  output logic          window_valid,
  input  logic          window_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);

  logic [2:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          acc;
  logic          at_col_end;
  logic          at_last;
  logic          win_hit;
  logic          win_take;

  // A pending, unaccepted window blocks new pixels so no window is overwritten.
  assign pix_ready  = ((state == S_FILL) || (state == S_ACTIVE)) &&
                      !(window_valid && !window_ready);
  assign acc        = pix_valid && pix_ready;
  assign at_col_end = (col == COL_LAST);
  assign at_last    = at_col_end && (row == ROW_LAST);
  assign win_hit    = acc && (row >= ROW_K) && (col >= COL_K);
  assign win_take   = window_valid && window_ready;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_FILL;
        S_FILL: begin
          if (acc && at_last)  state <= S_DRAIN;
          else if (win_hit)    state <= S_ACTIVE;
        end
        S_ACTIVE: if (acc && at_last) state <= S_DRAIN;
        S_DRAIN:  if (!window_valid || window_ready) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if ((state == S_IDLE) && start) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (at_col_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_enable       <= 1'b0;
      sr_shift_row_up <= 1'b0;
      sr_column_in    <= '0;
    end else begin
      sr_enable       <= acc;
      sr_shift_row_up <= acc && at_col_end;
      if (acc) sr_column_in <= pix_data;
    end
  end

  // A new window in the handshake cycle replaces the one being taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else if (win_hit) begin
      window_valid <= 1'b1;
      win_row      <= row - ROW_K;
      win_col      <= col - COL_K;
    end else if (win_take) begin
      window_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_sr_feeder.sv
// Randomized bench for ram_sr_feeder: a count-based frame model predicts every
// output cycle by cycle, and a raster-order window list checks window sequencing.
module tb_ram_sr_feeder;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int K     = 3;
  localparam int CW    = 3;
  localparam int RW    = 3;
  localparam int NWIN  = (H - K + 1) * (W - K + 1);
  localparam int BOUND = 3000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = 8'd0;
  logic          window_ready = 1'b0;
  logic          pix_ready;
  logic          sr_enable;
  logic [7:0]    sr_column_in;
  logic          sr_shift_row_up;
  logic          window_valid;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // Model: 0 idle, 1 taking pixels, 2 draining, 3 done
  int         m_mode, m_n, m_wr, m_wc;
  logic       m_wv, m_en, m_up;
  logic [7:0] m_col;
  int         q_r[$];
  int         q_c[$];
  int         o_en, o_up, o_win, o_done, o_acc;
  bit         seen_first;

  always #5 clock = ~clock;

  ram_sr_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .CW(CW), .RW(RW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .sr_enable(sr_enable), .sr_column_in(sr_column_in), .sr_shift_row_up(sr_shift_row_up),
    .window_valid(window_valid), .window_ready(window_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_mode = 0; m_n = 0; m_wr = 0; m_wc = 0;
    m_wv = 1'b0; m_en = 1'b0; m_up = 1'b0; m_col = 8'd0;
    q_r.delete();
    q_c.delete();
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_pix_ready"}, 32'(pix_ready), 0);
    checkOutput({pfx, "_sr_enable"}, 32'(sr_enable), 0);
    checkOutput({pfx, "_sr_column_in"}, 32'(sr_column_in), 0);
    checkOutput({pfx, "_row_up"}, 32'(sr_shift_row_up), 0);
    checkOutput({pfx, "_window_valid"}, 32'(window_valid), 0);
    checkOutput({pfx, "_win_row"}, 32'(win_row), 0);
    checkOutput({pfx, "_win_col"}, 32'(win_col), 0);
    checkOutput({pfx, "_busy"}, 32'(busy), 0);
    checkOutput({pfx, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // One cycle: drive at negedge, compare just after, advance model, wait posedge.
  task automatic applyStimulus(input logic st, input logic pv, input logic wr,
                               input logic rst, input int stall_kind);
    logic exp_ready, acc, old_wv;
    int   r, c;
    @(negedge clock);
    reset = rst; start = st; pix_valid = pv; window_ready = wr;
    pix_data = pv ? 8'(m_n) : 8'($urandom);
    #1;
    exp_ready = (m_mode == 1) && !(m_wv && !wr);
    checkOutput("pix_ready", 32'(pix_ready), 32'(exp_ready));
    checkOutput("sr_enable", 32'(sr_enable), 32'(m_en));
    checkOutput("sr_column_in", 32'(sr_column_in), 32'(m_col));
    checkOutput("row_up", 32'(sr_shift_row_up), 32'(m_up));
    checkOutput("window_valid", 32'(window_valid), 32'(m_wv));
    checkOutput("busy", 32'(busy), 32'(m_mode != 0));
    checkOutput("frame_done", 32'(frame_done), 32'(m_mode == 3));
    if (m_wv) begin
      checkOutput("win_row", 32'(win_row), m_wr);
      checkOutput("win_col", 32'(win_col), m_wc);
    end
    if (stall_kind == 1) begin
      checkOutput("stall_pix_ready", 32'(pix_ready), 0);
      checkOutput("stall_win_row", 32'(win_row), 1);
      checkOutput("stall_win_col", 32'(win_col), 2);
    end else if (stall_kind == 2) begin
      checkOutput("drain_pix_ready", 32'(pix_ready), 0);
      checkOutput("drain_busy", 32'(busy), 1);
      checkOutput("drain_frame_done", 32'(frame_done), 0);
    end

    if (window_valid && !seen_first) begin
      seen_first = 1'b1;
      checkOutput("first_win_accepts", o_acc, 19);
      checkOutput("first_win_row", 32'(win_row), 0);
      checkOutput("first_win_col", 32'(win_col), 0);
    end
    if (sr_enable) o_en++;
    if (sr_shift_row_up) begin
      o_up++;
      checkOutput("rowup_col_low", 32'(sr_column_in[2:0]), 7);
    end
    if (frame_done) o_done++;
    if (pv && pix_ready) o_acc++;
    if (window_valid && wr) begin
      o_win++;
      checkOutput("win_queue_nonempty", 32'(q_r.size() > 0), 1);
      if (q_r.size() > 0) begin
        checkOutput("win_seq_row", 32'(win_row), q_r.pop_front());
        checkOutput("win_seq_col", 32'(win_col), q_c.pop_front());
      end
    end

    if (rst) begin
      modelReset();
    end else begin
      acc    = pv && exp_ready;
      r      = m_n / W;
      c      = m_n % W;
      old_wv = m_wv;
      m_en   = acc;
      m_up   = acc && (c == W - 1);
      if (acc) m_col = pix_data;
      if (acc && r >= K - 1 && c >= K - 1) begin
        m_wv = 1'b1; m_wr = r - K + 1; m_wc = c - K + 1;
      end else if (old_wv && wr) begin
        m_wv = 1'b0;
      end
      case (m_mode)
        0: if (st) begin
          m_mode = 1; m_n = 0;
          q_r.delete(); q_c.delete();
          for (int rr = 0; rr <= H - K; rr++)
            for (int cc = 0; cc <= W - K; cc++) begin
              q_r.push_back(rr); q_c.push_back(cc);
            end
          o_en = 0; o_up = 0; o_win = 0; o_done = 0; o_acc = 0; seen_first = 1'b0;
        end
        1: if (acc) begin
          if (m_n == W * H - 1) m_mode = 2;
          m_n++;
        end
        2: if (!old_wv || wr) m_mode = 3;
        default: m_mode = 0;
      endcase
    end
    @(posedge clock);
  endtask

  // Patterns: 0 plain, 1 stall at window (1,2), 2 bubbles, 3 start mid-frame, 4 final stall
  task automatic runFrame(input int pattern);
    int   stall, cyc, kind;
    bit   pulsed;
    logic pv, wr, st;
    stall = 0; cyc = 0; pulsed = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
    while (m_mode != 0 && cyc < BOUND) begin
      pv = (pattern == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr = 1'b1; st = 1'b0; kind = 0;
      if (pattern == 1 && m_wv && m_wr == 1 && m_wc == 2 && stall < 5) begin
        wr = 1'b0; stall++; kind = 1;
      end
      if (pattern == 4 && m_mode == 2 && stall < 3) begin
        wr = 1'b0; stall++; kind = 2;
      end
      if (pattern == 3 && m_n == 40 && !pulsed) begin
        st = 1'b1; pulsed = 1'b1;
      end
      applyStimulus(st, pv, wr, 1'b0, kind);
      cyc++;
    end
    checkOutput("frame_end_reached", 32'(cyc < BOUND), 1);
    checkOutput("window_count", o_win, NWIN);
    checkOutput("enable_count", o_en, W * H);
    checkOutput("row_up_count", o_up, H);
    checkOutput("accept_count", o_acc, W * H);
    checkOutput("frame_done_count", o_done, 1);
    checkOutput("windows_left", 32'(q_r.size()), 0);
    if (pattern == 1) checkOutput("stall_cycles", stall, 5);
    if (pattern == 4) checkOutput("drain_stall_cycles", stall, 3);
    if (pattern == 3) checkOutput("start_pulsed", 32'(pulsed), 1);
    @(negedge clock);
    #1;
    checkOutput("busy_after_frame", 32'(busy), 0);
  endtask

  task automatic testResetMidFrame();
    int cyc;
    cyc = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
    while (m_n < 30 && cyc < 500) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
      cyc++;
    end
    checkOutput("reached_30_accepts", m_n, 30);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0);
    @(negedge clock);
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0;
    #1;
    checkAllZero("rst_mid");
    runFrame(0);
  endtask

  task automatic testIdleValid();
    int en_before;
    en_before = o_en;
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("idle_enable_count", o_en - en_before, 0);
    checkOutput("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    modelReset();
    o_en = 0; o_up = 0; o_win = 0; o_done = 0; o_acc = 0; seen_first = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checkAllZero("rst");
    runFrame(0);
    runFrame(1);
    runFrame(2);
    testIdleValid();
    testResetMidFrame();
    runFrame(3);
    runFrame(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
